// File: rtl/mix_out_sched.sv
// Mixer output scheduler: divides sys_clk into a sample strobe, captures the
// mixer product into a one-entry hold buffer and serializes it MSB-first as
// BW-bit bytes over a valid/ready handshake. Samples arriving while the hold
// buffer is occupied and not draining are dropped and counted.
module mix_out_sched #(
  parameter int DIV = 1042,
  parameter int DW  = 48,
  parameter int BW  = 8
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          enable,
  output logic          sample_tick,
  input  logic [DW-1:0] prod_data,
  output logic [BW-1:0] byte_data,
  output logic          byte_valid,
  input  logic          byte_ready,
  output logic          byte_sof,
  output logic          busy,
  output logic [15:0]   ovf_cnt
);

  localparam int              NB       = DW / BW;
  localparam int              IW       = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [15:0]     CNT_LAST = 16'(DIV - 1);
  localparam logic [IW-1:0]   IDX_LAST = IW'(NB - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [DW-1:0] hold_q, hold_d;
  logic [DW-1:0] shift_q, shift_d;
  logic          hold_full_q, hold_full_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [15:0]   ovf_cnt_q, ovf_cnt_d;
  logic          tick;
  logic          drain;

  assign tick = enable & (cnt_q == CNT_LAST);

  // Sample-rate divider: free-runs 0..DIV-1 while enabled, parked at 0 otherwise.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Serializer FSM next state; drain flags a hold-to-shift transfer this cycle.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    drain   = 1'b0;
    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          shift_d = hold_q;
          idx_d   = '0;
          drain   = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (byte_ready) begin
          if (idx_q != IDX_LAST) begin
            shift_d = shift_q << BW;
            idx_d   = idx_q + IW'(1);
          end else if (hold_full_q) begin
            // Back-to-back word: reload without an idle bubble.
            shift_d = hold_q;
            idx_d   = '0;
            drain   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Hold buffer and drop counter: a tick may capture when the slot frees this cycle.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    ovf_cnt_d   = ovf_cnt_q;
    if (drain) begin
      hold_full_d = 1'b0;
    end
    if (tick) begin
      if (!hold_full_q || drain) begin
        hold_d      = prod_data;
        hold_full_d = 1'b1;
      end else if (ovf_cnt_q != 16'hFFFF) begin
        ovf_cnt_d = ovf_cnt_q + 16'd1;
      end
    end
  end

  // Control and output-facing state, cleared asynchronously.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      hold_full_q <= 1'b0;
      idx_q       <= '0;
      ovf_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      hold_full_q <= hold_full_d;
      idx_q       <= idx_d;
      ovf_cnt_q   <= ovf_cnt_d;
    end
  end

  // Hold payload is only meaningful while hold_full_q is set, so it needs no reset.
  always_ff @(posedge sys_clk) begin
    hold_q <= hold_d;
  end

  assign byte_valid  = (state_q == SEND);
  assign byte_data   = shift_q[DW-1 -: BW];
  assign byte_sof    = byte_valid & (idx_q == '0);
  assign busy        = byte_valid | hold_full_q;
  assign ovf_cnt     = ovf_cnt_q;
  assign sample_tick = tick;

endmodule
